// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register feeding a 2-entry {pc, instr} FIFO toward decode.
// Define FETCH_TRACE_EN to print every push and redirect during simulation.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [13:0] rom_addr,
  input  logic [31:0] rom_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4
);

  logic [31:0] pc;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] buf_pc_p1    [2];
  logic [31:0] buf_instr_p1 [2];

  logic        pop;
  logic        fetch_en;
  logic        push;
  logic [31:0] target_pc;

  always_comb begin
    pop       = out_valid & out_ready;
    fetch_en  = (count != 2'd2) | pop;
    push      = fetch_en & ~redirect;
    target_pc = redirect_pc & ~32'd3;
  end

  assign rom_addr  = pc[15:2];
  assign out_valid = (count != 2'd0);
  assign out_pc    = buf_pc_p1[rd_ptr];
  assign out_instr = buf_instr_p1[rd_ptr];
  assign out_pc4   = buf_pc_p1[rd_ptr] + 32'd4;

  // Fetch -> FIFO boundary: control state, redirect wins over any push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (redirect) begin
      pc     <= target_pc;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_p1[wr_ptr]    <= pc;
      buf_instr_p1[wr_ptr] <= rom_instr;
    end
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && redirect) $display("redirect: pc=%h", target_pc);
    else if (!reset && push) $display("fetch: pc=%h instr=%h", pc, rom_instr);
  end
`else
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] rom_addr;
  logic [31:0] rom_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;

  logic [31:0] rom_mem [16384];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mpc;
  int          passes = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  assign rom_instr = rom_mem[rom_addr];

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_instr(rom_instr),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_check();
    chk("valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("rom_addr", {18'd0, rom_addr}, {18'd0, mpc[15:2]});
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].instr);
      chk("out_pc4", out_pc4, q[0].pc + 32'd4);
    end
  endtask

  // Advance one clock: model decides from the inputs it sees, then DUT is checked after the edge.
  task automatic tick();
    bit   pop;
    bit   room;
    ent_t e;
    pop  = (q.size() != 0) && out_ready;
    room = (q.size() != 2) || pop;
    if (reset) begin
      q.delete();
      mpc = RST_PC;
    end else if (redirect) begin
      q.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (pop) void'(q.pop_front());
      if (room) begin
        e.pc    = mpc;
        e.instr = rom_mem[mpc[15:2]];
        q.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    model_check();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h2008_0005;
    rom_mem[1] = 32'h2009_0007;

    // Reset overrides redirect and handshake.
    reset = 1'b1; redirect = 1'b1; redirect_pc = $urandom; out_ready = 1'b1;
    tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rom_addr", {18'd0, rom_addr}, 32'd0);
    tick();

    // First instructions after reset.
    reset = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    tick();
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_pc", out_pc, 32'h0040_0000);
    chk("first_instr", out_instr, 32'h2008_0005);
    tick();
    chk("second_pc", out_pc, 32'h0040_0004);
    chk("second_pc4", out_pc4, 32'h0040_0008);

    // Back-pressure saturates the FIFO, then drains in order.
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0;
    repeat (5) tick();
    chk("full_head_pc", out_pc, 32'h0040_0000);
    chk("full_rom_addr", {18'd0, rom_addr}, 32'd2);
    out_ready = 1'b1;
    chk("drain0", out_pc, 32'h0040_0000);
    tick();
    chk("drain1", out_pc, 32'h0040_0004);
    tick();
    chk("drain2", out_pc, 32'h0040_0008);

    // Redirect with a full FIFO, unaligned target.
    out_ready = 1'b0;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0040_0023;
    tick();
    redirect = 1'b0;
    chk("redir_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_rom_addr", {18'd0, rom_addr}, 32'h0000_0008);
    tick();
    chk("redir_target_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_target_pc", out_pc, 32'h0040_0020);

    // Redirect coinciding with a pop: popped entry delivered, the other discarded.
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0;
    tick(); tick();
    out_ready = 1'b1;
    tick();
    chk("pop_redir_head_valid", {31'd0, out_valid}, 32'd1);
    chk("pop_redir_head_pc", out_pc, 32'h0040_0004);
    redirect = 1'b1; redirect_pc = 32'h0040_0100;
    tick();
    redirect = 1'b0;
    repeat (6) begin
      chk("discarded_absent", {31'd0, out_valid && (out_pc == 32'h0040_0008)}, 32'd0);
      tick();
    end

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; out_ready = 1'b1;
    tick();
    redirect = 1'b0;
    chk("wrap_gap", {31'd0, out_valid}, 32'd0);
    tick();
    chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", out_pc4, 32'h0000_0000);
    tick();
    chk("wrap_pc1", out_pc, 32'h0000_0000);

    // Reset together with redirect while full.
    out_ready = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h1234_5678;
    tick();
    chk("rst_full_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_full_rom_addr", {18'd0, rom_addr}, 32'd0);
    reset = 1'b0; redirect = 1'b0;
    tick();
    chk("rst_full_pc", out_pc, 32'h0040_0000);

    // Randomized traffic.
    repeat (400) begin
      reset       = ($urandom % 40) == 0;
      redirect    = ($urandom % 8) == 0;
      redirect_pc = $urandom;
      out_ready   = ($urandom % 3) != 0;
      tick();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000: PC value loaded by reset.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 rom_addr  output  14  word address to instruction ROM, = pc[15:2].
REQ-005 rom_instr  input  32  combinational ROM read data for rom_addr.
REQ-006 redirect  input  1  taken branch/jump: discard buffered instructions and restart fetch.
REQ-007 redirect_pc  input  32  new fetch PC, valid when redirect=1.
REQ-008 out_valid  output  1  head entry holds a valid instruction.
REQ-009 out_ready  input  1  decode accepts the head entry this cycle.
REQ-010 out_instr  output  32  head instruction word.
REQ-011 out_pc  output  32  address of out_instr.
REQ-012 out_pc4  output  32  out_pc + 4, wrap modulo 2^32.

Function
REQ-013 State SHALL be a 32-bit pc register plus a 2-entry FIFO of {pc, instr} pairs with 2-bit count (0..2).
REQ-014 pop = out_valid & out_ready; a transfer completes on any posedge where pop=1.
REQ-015 fetch_en = (count != 2) | pop; when fetch_en=1 and redirect=0, the stage SHALL push {pc, rom_instr} and set pc <= pc + 4.
REQ-016 Simultaneous push and pop SHALL keep count unchanged; push-only increments, pop-only decrements.
REQ-017 Full FIFO (count=2) without pop SHALL hold pc and both entries; rom_addr stays stable.
REQ-018 out_valid = (count != 0); out_instr/out_pc/out_pc4 SHALL be driven from the head entry and are don't-care when out_valid=0.
REQ-019 Latency: an instruction fetched at edge N SHALL appear at the FIFO output in cycle N+1 (one cycle, no combinational ROM-to-output path).
REQ-020 redirect=1 SHALL have priority over all other events: count <= 0, pc <= {redirect_pc[31:2], 2'b00}, no push that cycle.
REQ-021 A pop coinciding with redirect SHALL count as a completed transfer; the remaining entry is discarded.
REQ-022 Instruction at redirect target SHALL be presented with out_valid=1 two cycles after the redirect edge (fetch one cycle, output the next).
REQ-023 pc + 4 SHALL wrap modulo 2^32; rom_addr SHALL use only pc[15:2] (aliasing of addresses above 64 KB is intended).
REQ-024 FIFO pointers SHALL wrap modulo 2; order of entries is strictly FIFO.

Reset
REQ-025 On posedge clk with reset=1: pc <= RESET_PC, count <= 0, read/write pointers <= 0; reset overrides redirect and handshake.
REQ-026 During and in the first cycle after reset: out_valid=0, rom_addr = RESET_PC[15:2] (14'h0000 for default).
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries in the same edge.

Configuration
REQ-028 Macro FETCH_TRACE_EN: when defined, each push SHALL $display "fetch: pc=%h instr=%h" and each redirect "redirect: pc=%h"; when undefined, no display statements are compiled and behaviour is otherwise identical.

Verification
REQ-029 Reset, out_ready=1, ROM[0]=32'h2008_0005, ROM[1]=32'h2009_0007 -> cycle 1 after reset out_valid=1 out_pc=0x0040_0000 out_instr=32'h2008_0005; next cycle out_pc=0x0040_0004 out_pc4=0x0040_0008.
REQ-030 out_ready=0 for 5 cycles after reset -> count saturates at 2, pc holds at 0x0040_0008, out_pc stays 0x0040_0000; raise out_ready -> entries 0x0040_0000, 0x0040_0004, 0x0040_0008 delivered in consecutive cycles.
REQ-031 redirect=1, redirect_pc=0x0040_0023 with full FIFO -> next cycle out_valid=0, rom_addr=14'h0008; following cycle out_pc=0x0040_0020.
REQ-032 redirect with simultaneous pop of 0x0040_0004 -> that entry counted delivered, entry 0x0040_0008 never appears on out_pc.
REQ-033 redirect_pc=32'hFFFF_FFFC, out_ready=1 -> out_pc sequence 0xFFFF_FFFC then 0x0000_0000; out_pc4 of first = 0x0000_0000.
REQ-034 reset asserted while count=2 and redirect=1 -> next cycle out_valid=0, pc=0x0040_0000.
